rgmii_rx_decoder: RTL and testbench



---
 rtl/rgmii_pkg.sv | 25 ++
 rtl/rgmii_rx_iddr.sv | 45 ++++
 rtl/rgmii_rx_decoder.sv | 225 ++++++++++++++++++++++
 tb/tb_rgmii_rx_decoder.sv | 309 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rgmii_pkg.sv
// rtl/rgmii_pkg.sv - shared constants, state encoding and helpers for the RGMII receive path
package rgmii_pkg;

    localparam logic [7:0] PREAMBLE_BYTE = 8'h55;
    localparam logic [7:0] SFD_BYTE      = 8'hD5;

    localparam logic [1:0] SPEED_10M  = 2'b00;
    localparam logic [1:0] SPEED_100M = 2'b01;
    localparam logic [1:0] SPEED_1G   = 2'b10;

    typedef enum logic [1:0] {
        IDLE,
        PREAMBLE,
        DATA,
        DROP
    } rx_state_e;

    // An inter-frame symbol carries link status only when it is a clean idle
    // with the same nibble on both clock edges.
    function automatic logic is_status_symbol(input logic dv, input logic er,
                                              input logic [3:0] lo, input logic [3:0] hi);
        return !dv && !er && (lo == hi);
    endfunction

endpackage

// File: rtl/rgmii_rx_iddr.sv
// rtl/rgmii_rx_iddr.sv - DDR capture of rxd[3:0] and rx_ctrl, realigned to rising-edge pairs
module rgmii_rx_iddr (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] rxd_i,
    input  logic       rx_ctrl_i,
    output logic [3:0] rxd_rise_o,
    output logic [3:0] rxd_fall_o,
    output logic       ctrl_rise_o,
    output logic       ctrl_fall_o
);

    // Behaves like five IDDRX1F cells: the rising sample and the falling sample
    // that follows it are presented together after the next rising edge.
    logic [4:0] rise_q;
    logic [4:0] fall_q;
    logic [4:0] rise_out_q;
    logic [4:0] fall_out_q;

    // Rising-edge sample, then hand both halves out on the next rising edge
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rise_q     <= '0;
            rise_out_q <= '0;
            fall_out_q <= '0;
        end else begin
            rise_q     <= {rx_ctrl_i, rxd_i};
            rise_out_q <= rise_q;
            fall_out_q <= fall_q;
        end
    end

    // Falling-edge sample of the second half of the DDR symbol
    always_ff @(negedge clk or posedge rst) begin
        if (rst) begin
            fall_q <= '0;
        end else begin
            fall_q <= {rx_ctrl_i, rxd_i};
        end
    end

    assign {ctrl_rise_o, rxd_rise_o} = rise_out_q;
    assign {ctrl_fall_o, rxd_fall_o} = fall_out_q;

endmodule

// File: rtl/rgmii_rx_decoder.sv
// rtl/rgmii_rx_decoder.sv - RGMII receive decode: GMII rebuild, in-band status, framed byte stream
module rgmii_rx_decoder
    import rgmii_pkg::*;
#(
    parameter int MIN_PREAMBLE = 1,
    parameter int MAX_FRAME    = 1522
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  rgmii_rxd,
    input  logic        rgmii_rx_ctrl,
    output logic [7:0]  gmii_rx_data,
    output logic        gmii_rx_en,
    output logic        gmii_rx_er,
    output logic [7:0]  rx_data,
    output logic        rx_valid,
    output logic        rx_sof,
    output logic        rx_eof,
    output logic        rx_err,
    output logic [15:0] rx_len,
    output logic        link_up,
    output logic [1:0]  link_speed,
    output logic        full_duplex,
    output logic [15:0] rx_frame_count,
    output logic [15:0] rx_bad_count
);

    logic [3:0] rxd_rise;
    logic [3:0] rxd_fall;
    logic       ctrl_rise;
    logic       ctrl_fall;

    rgmii_rx_iddr u_iddr (
        .clk         (clk),
        .rst         (rst),
        .rxd_i       (rgmii_rxd),
        .rx_ctrl_i   (rgmii_rx_ctrl),
        .rxd_rise_o  (rxd_rise),
        .rxd_fall_o  (rxd_fall),
        .ctrl_rise_o (ctrl_rise),
        .ctrl_fall_o (ctrl_fall)
    );

    logic [7:0] cap_byte;
    logic       cap_dv;
    logic       cap_er;

    assign cap_byte = {rxd_fall, rxd_rise};
    assign cap_dv   = ctrl_rise;
    assign cap_er   = ctrl_rise ^ ctrl_fall;

    logic [7:0] gmii_data_q;
    logic       gmii_en_q;
    logic       gmii_er_q;
    logic [3:0] status_q;

    // Registered GMII mirror of the captured symbol
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            gmii_data_q <= '0;
            gmii_en_q   <= 1'b0;
            gmii_er_q   <= 1'b0;
        end else begin
            gmii_data_q <= cap_byte;
            gmii_en_q   <= cap_dv;
            gmii_er_q   <= cap_er;
        end
    end

    // Latch in-band link status from clean inter-frame symbols only
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            status_q <= '0;
        end else if (is_status_symbol(cap_dv, cap_er, rxd_rise, rxd_fall)) begin
            status_q <= rxd_rise;
        end
    end

    rx_state_e   state_q;
    logic [3:0]  pcnt_q;
    logic [15:0] len_q;
    logic [15:0] len_d;
    logic [7:0]  hold_q;
    logic        first_q;
    logic        err_sticky_q;
    logic [7:0]  rx_data_q;
    logic        rx_valid_q;
    logic        rx_sof_q;
    logic        rx_eof_q;
    logic        rx_err_q;
    logic [15:0] rx_len_q;
    logic [15:0] frame_cnt_q;
    logic [15:0] bad_cnt_q;

    assign len_d = len_q + 16'd1;

    // Framing FSM: preamble/SFD hunt, one-byte hold for end-of-frame lookahead, counters
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            pcnt_q       <= '0;
            len_q        <= '0;
            hold_q       <= '0;
            first_q      <= 1'b0;
            err_sticky_q <= 1'b0;
            rx_data_q    <= '0;
            rx_valid_q   <= 1'b0;
            rx_sof_q     <= 1'b0;
            rx_eof_q     <= 1'b0;
            rx_err_q     <= 1'b0;
            rx_len_q     <= '0;
            frame_cnt_q  <= '0;
            bad_cnt_q    <= '0;
        end else begin
            rx_valid_q <= 1'b0;
            rx_sof_q   <= 1'b0;
            rx_eof_q   <= 1'b0;
            rx_err_q   <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (cap_dv) begin
                        if (cap_byte == PREAMBLE_BYTE) begin
                            state_q <= PREAMBLE;
                            pcnt_q  <= 4'd1;
                        end else if (cap_byte == SFD_BYTE && MIN_PREAMBLE == 0) begin
                            state_q      <= DATA;
                            len_q        <= '0;
                            err_sticky_q <= 1'b0;
                            first_q      <= 1'b1;
                        end else begin
                            state_q   <= DROP;
                            bad_cnt_q <= bad_cnt_q + 16'd1;
                        end
                    end
                end
                PREAMBLE: begin
                    if (!cap_dv) begin
                        state_q <= IDLE;
                    end else if (cap_er) begin
                        state_q   <= DROP;
                        bad_cnt_q <= bad_cnt_q + 16'd1;
                    end else if (cap_byte == PREAMBLE_BYTE) begin
                        if (pcnt_q != 4'd15) begin
                            pcnt_q <= pcnt_q + 4'd1;
                        end
                    end else if (cap_byte == SFD_BYTE && int'(pcnt_q) >= MIN_PREAMBLE) begin
                        state_q      <= DATA;
                        len_q        <= '0;
                        err_sticky_q <= 1'b0;
                        first_q      <= 1'b1;
                    end else begin
                        state_q   <= DROP;
                        bad_cnt_q <= bad_cnt_q + 16'd1;
                    end
                end
                DATA: begin
                    if (!cap_dv) begin
                        state_q <= IDLE;
                        if (len_q != 16'd0) begin
                            rx_data_q  <= hold_q;
                            rx_valid_q <= 1'b1;
                            rx_sof_q   <= first_q;
                            rx_eof_q   <= 1'b1;
                            rx_err_q   <= err_sticky_q;
                            rx_len_q   <= len_q;
                            first_q    <= 1'b0;
                            if (err_sticky_q) begin
                                bad_cnt_q <= bad_cnt_q + 16'd1;
                            end else begin
                                frame_cnt_q <= frame_cnt_q + 16'd1;
                            end
                        end else begin
                            bad_cnt_q <= bad_cnt_q + 16'd1;
                        end
                    end else if (len_q == 16'(MAX_FRAME)) begin
                        // Frame overran: close it on the held byte and discard the rest
                        state_q    <= DROP;
                        rx_data_q  <= hold_q;
                        rx_valid_q <= 1'b1;
                        rx_sof_q   <= first_q;
                        rx_eof_q   <= 1'b1;
                        rx_err_q   <= 1'b1;
                        rx_len_q   <= len_q;
                        first_q    <= 1'b0;
                        bad_cnt_q  <= bad_cnt_q + 16'd1;
                    end else begin
                        hold_q <= cap_byte;
                        len_q  <= len_d;
                        if (cap_er) begin
                            err_sticky_q <= 1'b1;
                        end
                        if (len_q != 16'd0) begin
                            rx_data_q  <= hold_q;
                            rx_valid_q <= 1'b1;
                            rx_sof_q   <= first_q;
                            first_q    <= 1'b0;
                        end
                    end
                end
                DROP: begin
                    if (!cap_dv) begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign gmii_rx_data   = gmii_data_q;
    assign gmii_rx_en     = gmii_en_q;
    assign gmii_rx_er     = gmii_er_q;
    assign rx_data        = rx_data_q;
    assign rx_valid       = rx_valid_q;
    assign rx_sof         = rx_sof_q;
    assign rx_eof         = rx_eof_q;
    assign rx_err         = rx_err_q;
    assign rx_len         = rx_len_q;
    assign link_up        = status_q[0];
    assign link_speed     = status_q[2:1];
    assign full_duplex    = status_q[3];
    assign rx_frame_count = frame_cnt_q;
    assign rx_bad_count   = bad_cnt_q;

endmodule

// File: tb/tb_rgmii_rx_decoder.sv
// tb/tb_rgmii_rx_decoder.sv - self-checking bench for rgmii_rx_decoder
module tb_rgmii_rx_decoder;
    import rgmii_pkg::*;

    localparam int MIN_PRE = 1;
    localparam int MAXF    = 64;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  rgmii_rxd;
    logic        rgmii_rx_ctrl;
    logic [7:0]  gmii_rx_data;
    logic        gmii_rx_en;
    logic        gmii_rx_er;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_sof;
    logic        rx_eof;
    logic        rx_err;
    logic [15:0] rx_len;
    logic        link_up;
    logic [1:0]  link_speed;
    logic        full_duplex;
    logic [15:0] rx_frame_count;
    logic [15:0] rx_bad_count;

    rgmii_rx_decoder #(.MIN_PREAMBLE(MIN_PRE), .MAX_FRAME(MAXF)) dut (
        .clk            (clk),
        .rst            (rst),
        .rgmii_rxd      (rgmii_rxd),
        .rgmii_rx_ctrl  (rgmii_rx_ctrl),
        .gmii_rx_data   (gmii_rx_data),
        .gmii_rx_en     (gmii_rx_en),
        .gmii_rx_er     (gmii_rx_er),
        .rx_data        (rx_data),
        .rx_valid       (rx_valid),
        .rx_sof         (rx_sof),
        .rx_eof         (rx_eof),
        .rx_err         (rx_err),
        .rx_len         (rx_len),
        .link_up        (link_up),
        .link_speed     (link_speed),
        .full_duplex    (full_duplex),
        .rx_frame_count (rx_frame_count),
        .rx_bad_count   (rx_bad_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0]  data;
        logic        sof;
        logic        eof;
        logic        err;
        logic [15:0] len;
    } exp_t;

    typedef struct {
        logic [3:0] rn;
        logic [3:0] fn;
        logic       cr;
        logic       cf;
        logic [3:0] exp_status;
        int         bad_inc;
    } status_vec_t;

    exp_t       exp_q[$];
    logic [7:0] fb[$];
    logic       fe[$];
    int         n_checks = 0;
    int         n_fail   = 0;
    int         cyc      = 0;
    int         sof_cyc  = -1;
    bit         sb_en    = 1'b0;
    int         exp_good = 0;
    int         exp_bad  = 0;
    logic [7:0] h_b[2];
    logic       h_dv[2];
    logic       h_er[2];
    int         hist_n   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // One DDR symbol: rise half sampled at the posedge, fall half at the following negedge
    task automatic drive_raw(input logic [4:0] r, input logic [4:0] f);
        {rgmii_rx_ctrl, rgmii_rxd} = r;
        @(posedge clk);
        cyc++;
        #1;
        {rgmii_rx_ctrl, rgmii_rxd} = f;
        @(negedge clk);
        #1;
        if (hist_n >= 2)
            check("gmii_mirror", {gmii_rx_en, gmii_rx_er, gmii_rx_data}, {h_dv[1], h_er[1], h_b[1]});
        h_b[1]  = h_b[0];
        h_dv[1] = h_dv[0];
        h_er[1] = h_er[0];
        h_b[0]  = {f[3:0], r[3:0]};
        h_dv[0] = r[4];
        h_er[0] = r[4] ^ f[4];
        hist_n++;
    endtask

    task automatic drive_byte(input logic [7:0] b, input logic er);
        drive_raw({1'b1, b[3:0]}, {~er, b[7:4]});
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive_raw(5'h0D, 5'h0D);
    endtask

    // Reference: what a frame of (byte, er) pairs should produce, from the framing rules
    task automatic model();
        int n;
        int start;
        int pc;
        int m;
        bit drop;
        bit err;
        n = fb.size();
        start = -1;
        drop = 1'b0;
        if (n == 0) return;
        if (fb[0] == 8'h55) begin
            pc = 1;
            for (int i = 1; i < n; i++) begin
                if (fe[i]) begin drop = 1'b1; break; end
                if (fb[i] == 8'h55) begin
                    pc = (pc < 15) ? pc + 1 : 15;
                end else if (fb[i] == 8'hD5 && pc >= MIN_PRE) begin
                    start = i + 1;
                    break;
                end else begin
                    drop = 1'b1;
                    break;
                end
            end
        end else if (fb[0] == 8'hD5 && MIN_PRE == 0) begin
            start = 1;
        end else begin
            drop = 1'b1;
        end
        if (drop) begin exp_bad++; return; end
        if (start < 0) return;
        m = n - start;
        if (m == 0) begin
            exp_bad++;
        end else if (m > MAXF) begin
            for (int j = 0; j < MAXF; j++)
                exp_q.push_back('{fb[start + j], j == 0, j == MAXF - 1, j == MAXF - 1, 16'(MAXF)});
            exp_bad++;
        end else begin
            err = 1'b0;
            for (int j = start; j < n; j++) err |= fe[j];
            for (int j = 0; j < m; j++)
                exp_q.push_back('{fb[start + j], j == 0, j == m - 1, (j == m - 1) && err, 16'(m)});
            if (err) exp_bad++; else exp_good++;
        end
    endtask

    task automatic send_frame(input string tag);
        model();
        for (int j = 0; j < fb.size(); j++) drive_byte(fb[j], fe[j]);
        idle(5);
        check({tag, "_drained"}, 64'(exp_q.size()), 64'd0);
        check({tag, "_frames"}, 64'(rx_frame_count), 64'(exp_good[15:0]));
        check({tag, "_bad"}, 64'(rx_bad_count), 64'(exp_bad[15:0]));
    endtask

    task automatic build(input int npre, input int npay, input int base, input int er_at);
        fb.delete();
        fe.delete();
        for (int i = 0; i < npre; i++) begin fb.push_back(8'h55); fe.push_back(1'b0); end
        fb.push_back(8'hD5);
        fe.push_back(1'b0);
        for (int i = 0; i < npay; i++) begin
            fb.push_back(8'(base + i));
            fe.push_back(i == er_at);
        end
    endtask

    // Stream scoreboard
    always @(negedge clk) begin
        exp_t e;
        if (!rst && sb_en && rx_valid) begin
            if (rx_sof) sof_cyc = cyc;
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL stream_unexpected actual=%0h required=no_output", rx_data);
            end else begin
                e = exp_q.pop_front();
                check("stream_byte", {rx_data, rx_sof, rx_eof, rx_err, rx_eof ? rx_len : 16'h0},
                      {e.data, e.sof, e.eof, e.err, e.eof ? e.len : 16'h0});
            end
        end
    end

    status_vec_t vecs[8];

    initial begin
        int base;
        vecs[0] = '{4'hD, 4'hD, 1'b0, 1'b0, {1'b1, SPEED_1G, 1'b1}, 0};
        vecs[1] = '{4'hD, 4'h5, 1'b0, 1'b0, 4'hD, 0};
        vecs[2] = '{4'h3, 4'h3, 1'b0, 1'b0, {1'b0, SPEED_100M, 1'b1}, 0};
        vecs[3] = '{4'h0, 4'h0, 1'b0, 1'b1, 4'h3, 0};
        vecs[4] = '{4'h0, 4'h0, 1'b1, 1'b1, 4'h3, 1};
        vecs[5] = '{4'hA, 4'hA, 1'b0, 1'b0, {1'b1, SPEED_100M, 1'b0}, 0};
        vecs[6] = '{4'h9, 4'h9, 1'b0, 1'b0, {1'b1, SPEED_10M, 1'b1}, 0};
        vecs[7] = '{4'hD, 4'hD, 1'b0, 1'b0, 4'hD, 0};

        rst = 1'b1;
        {rgmii_rx_ctrl, rgmii_rxd} = 5'h0D;
        repeat (3) @(negedge clk);
        check("reset_state", {rx_valid, rx_sof, rx_eof, rx_err, rx_len, rx_data, gmii_rx_data,
                              gmii_rx_en, gmii_rx_er, link_up, link_speed, full_duplex,
                              rx_frame_count, rx_bad_count}, 64'd0);
        rst = 1'b0;
        hist_n = 0;
        sb_en = 1'b1;
        idle(2);

        for (int v = 0; v < 8; v++) begin
            for (int k = 0; k < 3; k++)
                drive_raw({vecs[v].cr, vecs[v].rn}, {vecs[v].cf, vecs[v].fn});
            exp_bad += vecs[v].bad_inc;
            check("inband_status", {full_duplex, link_speed, link_up}, vecs[v].exp_status);
        end
        idle(3);
        check("status_bad", 64'(rx_bad_count), 64'(exp_bad));

        // Good frame, exactly MAX_FRAME payload bytes
        build(7, 64, 0, -1);
        base = cyc;
        send_frame("good64");
        check("sof_latency", 64'(sof_cyc), 64'(base + 8 + 1 + 3));
        check("good64_count", 64'(rx_frame_count), 64'd1);

        // RX_ER on byte 10 of 20
        build(3, 20, 8'h80, 10);
        send_frame("rxer");

        // Bad preamble then a normal frame
        fb.delete(); fe.delete();
        fb = '{8'h55, 8'h55, 8'h5D, 8'hD5, 8'h01, 8'h02, 8'h03};
        fe = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        send_frame("badpre");
        build(2, 5, 8'h40, -1);
        send_frame("after_bad");

        // Oversize: 70 bytes against a 64-byte limit
        build(4, 70, 8'h10, -1);
        send_frame("oversize");

        // Single-byte and empty frames
        build(1, 1, 8'hA5, -1);
        send_frame("single");
        build(1, 0, 0, -1);
        send_frame("empty");

        // Randomized frames
        for (int t = 0; t < 40; t++) begin
            int p;
            int m;
            p = $urandom_range(0, 8);
            m = $urandom_range(0, 80);
            build(p, m, $urandom_range(0, 255), -1);
            for (int j = p + 1; j < fb.size(); j++) fb[j] = 8'($urandom_range(0, 255));
            if (p > 0 && $urandom_range(0, 9) == 0) fb[$urandom_range(0, p - 1)] = 8'($urandom_range(0, 255));
            if (m > 0 && $urandom_range(0, 4) == 0) fe[p + 1 + $urandom_range(0, m - 1)] = 1'b1;
            send_frame("random");
        end

        // Reset in the middle of a frame
        sb_en = 1'b0;
        build(3, 5, 8'h20, -1);
        for (int j = 0; j < fb.size(); j++) drive_byte(fb[j], 1'b0);
        rst = 1'b1;
        #1;
        check("reset_midframe", {rx_valid, rx_sof, rx_eof, rx_err, rx_len, rx_data, gmii_rx_data,
                                 gmii_rx_en, gmii_rx_er, link_up, link_speed, full_duplex,
                                 rx_frame_count, rx_bad_count}, 64'd0);
        {rgmii_rx_ctrl, rgmii_rxd} = 5'h0D;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        exp_q.delete();
        exp_good = 0;
        exp_bad = 0;
        hist_n = 0;
        sb_en = 1'b1;
        idle(6);
        check("post_reset_counts", {rx_frame_count, rx_bad_count}, 64'd0);
        check("post_reset_status", {full_duplex, link_speed, link_up}, {1'b1, SPEED_1G, 1'b1});
        build(1, 0, 0, -1);
        send_frame("empty_after_reset");
        check("empty_bad_one", 64'(rx_bad_count), 64'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
